// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 multiplier datapath and its product accumulator.
package mult_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/product_accumulator.sv
// Sums each group of N consecutive unsigned products and presents the group
// sum with a sticky carry-out flag on a valid/ready output.
module product_accumulator #(
  parameter int PROD_W = mult_pkg::PROD_W,
  parameter int ACC_W  = 16,
  parameter int N      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  import mult_pkg::*;

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  acc_state_e       state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             ovf_r;

  logic [ACC_W:0]   sum_s;
  logic             accept_s;
  logic             last_s;

  // One extra bit on the adder captures the carry out of the ACC_W-bit sum.
  assign sum_s = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};

  assign accept_s = in_valid && in_ready;
  assign last_s   = (count_r == CNT_LAST);

  // Input readiness depends only on reset, clear and state, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (rst && !clr && (state_r == ACCUM)) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  // Accumulate / hold FSM with registered group outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ACCUM;
      acc_r     <= {ACC_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= {ACC_W{1'b0}};
      out_ovf   <= 1'b0;
    end else if (clr) begin
      state_r   <= ACCUM;
      acc_r     <= {ACC_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= {ACC_W{1'b0}};
      out_ovf   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_r <= sum_s[ACC_W-1:0];
            ovf_r <= ovf_r | sum_s[ACC_W];
            if (last_s) begin
              count_r   <= {CNT_W{1'b0}};
              out_sum   <= sum_s[ACC_W-1:0];
              out_ovf   <= ovf_r | sum_s[ACC_W];
              out_valid <= 1'b1;
              state_r   <= HOLD;
            end else begin
              count_r <= count_r + CNT_ONE;
            end
          end
        end
        HOLD: begin
          // Group sum stays on out_* after release until the next group completes.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            ovf_r     <= 1'b0;
            state_r   <= ACCUM;
          end
        end
        default: begin
          state_r <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the 4x4 multiplier's 8-bit product. Accepts a stream of products over a valid/ready handshake and sums each group of N consecutive products into a wider accumulator. Presents the finished group sum, with a sticky overflow flag, on a valid/ready output. Forms the accumulate half of a multiply-accumulate (dot-product) datapath.

## Interface
- PROD_W, 8: product width, matching the multiplier output.
- ACC_W, 16: accumulator and sum width. Must satisfy ACC_W >= PROD_W.
- N, 4: products per group. Must satisfy N >= 1.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous clear, active-high.
- in_valid  input  1  in_prod holds a valid product.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  PROD_W  unsigned product.
- out_valid  output  1  out_sum and out_ovf hold a finished group.
- out_ready  input  1  consumer takes the group this cycle.
- out_sum  output  ACC_W  group sum, modulo 2^ACC_W.
- out_ovf  output  1  at least one carry out of ACC_W occurred in this group.

## Operation
- Two states: ACCUM and HOLD.
- Reset (rst=0), asynchronous: state ACCUM, accumulator 0, count 0, ovf 0, out_valid 0, out_sum 0, out_ovf 0. While rst=0, in_ready is 0.
- ACCUM:
  - in_ready=1. A product is accepted when in_valid && in_ready.
  - On accept, the accumulator gets acc + zero-extended in_prod, truncated to ACC_W bits.
  - On accept, ovf |= carry out of that add, and count increments.
  - On the accept with count==N-1: out_sum is registered as acc+in_prod, out_ovf as the updated ovf, out_valid goes to 1, and the state moves to HOLD.
- HOLD:
  - in_ready=0. out_sum and out_ovf are held stable.
  - When out_ready=1: out_valid goes to 0; acc, count and ovf are cleared; the state returns to ACCUM.
- clr=1 (when rst=1): takes effect the same as reset, on the clock edge. Any product offered in that cycle is discarded and not accepted (in_ready is 0 while clr=1).
- Priority: rst > clr > handshake.
- Arithmetic: unsigned only. Wrap is silent in out_sum and reported only through out_ovf.
- Parameter N=1: every accepted product forms its own group.

## Timing
- Latency: out_valid rises on the edge that accepts the Nth product, so it is visible 1 cycle after that accept.
- Throughput: at most one group per N+1 cycles. HOLD lasts at least 1 cycle, and no product is accepted in HOLD.
- Output handshake:
  - Once out_valid=1, out_valid, out_sum and out_ovf stay constant until the cycle in which out_ready=1.
  - out_ready is ignored while out_valid=0.
- Input handshake: in_ready depends only on state and clr, never combinationally on in_valid.
- A product held on in_prod while the block is in HOLD is accepted in the first ACCUM cycle.
- out_* registers are unchanged in ACCUM until the group completes.

## Structure
- Shared package mult_pkg holds:
  - PROD_W = 8, the product width common to the multiplier and this block.
  - State encodings ACCUM=1'b0 and HOLD=1'b1.
- Count width is max(1, $clog2(N)), declared locally.
- Single module with no sub-modules. The counter, the adder with its carry and the FSM are inline.

## Test plan
- Group sum, defaults: four products of 70 (7*10) with in_valid held high. Required: out_valid=1 one cycle after the 4th accept, out_sum=280, out_ovf=0. in_ready=0 during HOLD, then 1 again after out_ready.
- Backpressure: complete a group of 10, 20, 30, 40, hold out_ready=0 for 5 cycles while offering a product of 50. Required: out_sum=100 stable and in_ready=0 throughout. The 50 is accepted only after the out_ready pulse and becomes the first term of the next group.
- Overflow, ACC_W=9: products 200, 200, 200, 1. Required: out_sum=89 (601-512), out_ovf=1. The next group 1, 1, 1, 1 gives out_sum=4, out_ovf=0.
- clr mid-group: accept 70 and 70, then assert clr for 1 cycle while offering 99. Follow with 1, 2, 3, 4. Required: the 99 is dropped and out_sum=10.
- Async reset mid-operation: drop rst between clock edges after 3 accepts, in HOLD and in ACCUM. Required: all outputs go to 0 immediately, without waiting for a clock edge. After rst is released, a fresh group of 5, 5, 5, 5 gives out_sum=20.
- N=1: stream products 255 and 0. Required: two groups, with out_sum=255 then out_sum=0, and each group's out_valid visible 1 cycle after its accept.
